apb_slave_fifo: RTL and testbench



---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_slave_fifo_sync_fifo.sv | 70 +++++++
 rtl/apb_slave_fifo.sv | 123 ++++++++++++
 tb/tb_apb_slave_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB write-buffer completer.
package apb_pkg;

    // Completer transfer states; see the state table in apb_slave_fifo.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

    localparam int APB_DATA_W = 8;

    // Wide enough for WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slave_fifo_sync_fifo.sv
// Small synchronous FIFO with registered storage and combinational head read.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Qualify push/pop and compute next pointers, count and storage.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers with synchronous reset; storage is not reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/apb_slave_fifo.sv
// APB write completer feeding a FIFO drained over a valid/ready stream.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transfer; waiting for a SETUP phase (PSEL=1, PENABLE=0)
// WAIT  | access phase; counting down wait states, stalls while full
// RESP  | PREADY high for one cycle; write data pushed at the next edge
module apb_slave_fifo
    import apb_pkg::*;
#(
    parameter  int m           = APB_DATA_W,
    parameter  int DEPTH       = 4,
    parameter  int WAIT_STATES = 0,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [m-1:0]  PWDATA,
    output logic          PREADY,
    output logic          PRDATA,
    output logic [m-1:0]  o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [CW-1:0] o_count
);

    apb_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  prdata_q, prdata_d;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic                  acc_go;

    // Access phase may complete: selected, wait states spent, and room for a write.
    assign acc_go = PSEL && (cnt_q == '0) && PENABLE && (!PWRITE || !full);

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (PSEL && !PENABLE) state_d = WAIT;
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (acc_go) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: wait-counter load/decrement, response strobe, FIFO push.
    always_comb begin
        cnt_d    = cnt_q;
        pready_d = 1'b0;
        prdata_d = 1'b0;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) cnt_d = WAIT_CNT_W'(WAIT_STATES);
            end
            WAIT: begin
                if (PSEL && (cnt_q != '0)) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else if (acc_go) begin
                    pready_d = 1'b1;
                    prdata_d = !PWRITE && full;
                end
            end
            RESP:    push = PWRITE;
            default: ;
        endcase
    end

    // Wait counter and registered response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q    <= '0;
            pready_q <= 1'b0;
            prdata_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

    sync_fifo #(
        .W     (m),
        .DEPTH (DEPTH)
    ) u_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .push   (push),
        .din    (PWDATA),
        .pop    (i_ready),
        .dout   (o_data),
        .count  (o_count),
        .full   (full),
        .empty  (empty)
    );

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign o_valid = !empty;

endmodule

// File: tb/tb_apb_slave_fifo.sv
// Bench: two completers (0 and 3 wait states) against a queue model.
module tb_apb_slave_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       preset  = 1'b1;
    logic       psel0   = 1'b0;
    logic       psel1   = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] pwdata  = 8'h00;
    logic       ir0     = 1'b0;
    logic       ir1     = 1'b0;

    logic       pready0, pready1, prdata0, prdata1, ov0, ov1;
    logic [7:0] od0, od1;
    logic [2:0] oc0, oc1;

    apb_slave_fifo #(.m(8), .DEPTH(4), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready0), .PRDATA(prdata0),
        .o_data(od0), .o_valid(ov0), .i_ready(ir0), .o_count(oc0)
    );

    apb_slave_fifo #(.m(8), .DEPTH(4), .WAIT_STATES(3)) dut3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready1), .PRDATA(prdata1),
        .o_data(od1), .o_valid(ov1), .i_ready(ir1), .o_count(oc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each completer is a byte queue; pushes are announced by the master.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         pp0 = 1'b0, pp1 = 1'b0;
    logic [7:0] pd0 = 8'h00, pd1 = 8'h00;
    bit         armed = 1'b0;

    always @(posedge clk) begin
        if (preset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (ir0 && q0.size() != 0) void'(q0.pop_front());
            if (pp0) q0.push_back(pd0);
            if (ir1 && q1.size() != 0) void'(q1.pop_front());
            if (pp1) q1.push_back(pd1);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("count0", 32'(oc0), q0.size());
            chk("valid0", 32'(ov0), 32'(q0.size() != 0));
            if (q0.size() != 0) chk("data0", 32'(od0), 32'(q0[0]));
            chk("count1", 32'(oc1), q1.size());
            chk("valid1", 32'(ov1), 32'(q1.size() != 0));
            if (q1.size() != 0) chk("data1", 32'(od1), 32'(q1[0]));
        end
    end

    // One APB transfer, started #1 after a posedge; returns #1 after the completion edge.
    // exp_k: negedge index (after SETUP is sampled) at which PREADY must first be seen high.
    task automatic xfer(input int inst, input bit wr, input logic [7:0] d,
                        input int exp_k, input bit exp_rd);
        bit   seen;
        logic rdy, rdat;
        if (inst == 0) psel0 = 1'b1; else psel1 = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        pwdata  = d;
        @(posedge clk);
        #1 penable = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= exp_k + 4 && !seen; k++) begin
            @(negedge clk);
            rdy  = (inst == 0) ? pready0 : pready1;
            rdat = (inst == 0) ? prdata0 : prdata1;
            if (rdy) begin
                seen = 1'b1;
                chk("ready_cycle", k, exp_k);
                chk("prdata", 32'(rdat), 32'(exp_rd));
                if (wr) begin
                    if (inst == 0) begin pp0 = 1'b1; pd0 = d; end
                    else           begin pp1 = 1'b1; pd1 = d; end
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: PREADY never high, expected at cycle %0d", exp_k);
        end
        @(posedge clk);
        #1;
        pp0 = 1'b0;
        pp1 = 1'b0;
        psel0 = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_pready0", 32'(pready0), 0);
        chk("rst_prdata0", 32'(prdata0), 0);
        chk("rst_count0",  32'(oc0), 0);
        chk("rst_valid0",  32'(ov0), 0);
        chk("rst_pready1", 32'(pready1), 0);
        chk("rst_count1",  32'(oc1), 0);

        // Single write, no wait states.
        @(posedge clk); #1;
        xfer(0, 1'b1, 8'hA5, 2, 1'b0);
        @(negedge clk);
        chk("t1_pready_one_cycle", 32'(pready0), 0);
        chk("t1_valid", 32'(ov0), 1);
        chk("t1_data",  32'(od0), 32'h A5);
        chk("t1_count", 32'(oc0), 1);
        @(posedge clk); #1 ir0 = 1'b1;
        @(posedge clk); #1 ir0 = 1'b0;

        // Fill to four, fifth write stalls until one pop frees a slot.
        for (int i = 1; i <= 4; i++) xfer(0, 1'b1, 8'(i), 2, 1'b0);
        fork
            xfer(0, 1'b1, 8'h05, 7, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1 ir0 = 1'b1;
                @(posedge clk);
                #1 ir0 = 1'b0;
            end
        join
        @(negedge clk);
        chk("t3_model_size", q0.size(), 4);
        chk("t3_data",  32'(od0), 32'h02);
        chk("t3_count", 32'(oc0), 4);

        // Status reads: full then empty.
        @(posedge clk); #1;
        xfer(0, 1'b0, 8'h00, 2, 1'b1);
        ir0 = 1'b1;
        repeat (4) @(posedge clk);
        #1 ir0 = 1'b0;
        @(negedge clk);
        chk("t4_drained", 32'(oc0), 0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 8'h00, 2, 1'b0);

        // Push and pop in the same cycle at count 2, across pointer wrap.
        xfer(0, 1'b1, 8'h10, 2, 1'b0);
        xfer(0, 1'b1, 8'h11, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fork
                xfer(0, 1'b1, 8'(8'h20 + i), 2, 1'b0);
                begin
                    repeat (2) @(posedge clk);
                    #1 ir0 = 1'b1;
                    @(posedge clk);
                    #1 ir0 = 1'b0;
                end
            join
        end
        @(negedge clk);
        chk("t5_data",  32'(od0), 32'h24);
        chk("t5_count", 32'(oc0), 2);

        // Three wait states: completion three cycles later than above.
        @(posedge clk); #1;
        xfer(1, 1'b1, 8'h3C, 5, 1'b0);
        @(negedge clk);
        chk("t2_data",  32'(od1), 32'h3C);
        chk("t2_count", 32'(oc1), 1);

        // Reset while completer 1 is in its access phase.
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'hEE;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        preset = 1'b1;
        @(posedge clk);
        #1 preset = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_wait_pready", 32'(pready1), 0);
        end
        chk("t6_count1", 32'(oc1), 0);

        // Reset during the response cycle of completer 0.
        xfer(0, 1'b1, 8'h55, 2, 1'b0);
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'hEE;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_resp_pready", 32'(pready0), 1);
        preset = 1'b1;
        @(posedge clk);
        #1 preset = 1'b0;
        psel0 = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        chk("t6_post_pready", 32'(pready0), 0);
        chk("t6_post_count",  32'(oc0), 0);
        chk("t6_post_valid",  32'(ov0), 0);

        // Next write shows up alone; the aborted byte was never stored.
        @(posedge clk); #1;
        xfer(0, 1'b1, 8'h77, 2, 1'b0);
        @(negedge clk);
        chk("t6_next_data",  32'(od0), 32'h77);
        chk("t6_next_count", 32'(oc0), 1);
        @(posedge clk); #1 ir0 = 1'b1;
        @(posedge clk); #1 ir0 = 1'b0;
        @(negedge clk);
        chk("t6_empty_after", 32'(ov0), 0);

        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
